// File: rtl/vrf_pkg.sv
// vrf_pkg: shared types and elaboration-time helpers for the XOR-bank
// vector register file slice (vrf_xor_mp and vrf_xor_bank).
package vrf_pkg;

  // Clear sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } vrf_state_e;

  // Address width for a given depth; depth 1 still needs one address bit
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Cross-bank read-index table, forward direction: which LVT copy inside
  // `bank` serves write port `port` (port != bank). A bank never reads
  // itself, so the copies are numbered over the remaining ports.
  function automatic int lvt_copy_idx(input int port, input int bank);
    return (port < bank) ? port : port - 1;
  endfunction

  // Same table, reverse direction: which write port LVT copy `copy` of
  // `bank` serves.
  function automatic int lvt_port_of(input int bank, input int copy);
    return (copy < bank) ? copy : copy + 1;
  endfunction

endpackage

// File: rtl/vrf_xor_bank.sv
// vrf_xor_bank: one XOR bank. N_COPIES replicated memories share a single
// byte-enabled write port; each copy has its own read address, a bypass
// that forwards the word being committed this cycle, and a registered
// read output.
module vrf_xor_bank
  import vrf_pkg::*;
#(
  parameter int DEPTH    = 512,
  parameter int WIDTH    = 32,
  parameter int NB       = WIDTH / 8,
  parameter int N_COPIES = 6,
  parameter bit USE_BRAM = 1'b0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NB-1:0]                           we_be,
  input  logic [addr_w(DEPTH)-1:0]                waddr,
  input  logic [WIDTH-1:0]                        wdata,
  input  logic [N_COPIES-1:0][addr_w(DEPTH)-1:0]  raddr,
  input  logic [N_COPIES-1:0]                     ren,
  input  logic                                    rflush,
  output logic [N_COPIES-1:0][WIDTH-1:0]          rdata
);

  for (genvar c = 0; c < N_COPIES; c++) begin : g_copy
    logic [WIDTH-1:0] mem_rd;
    logic [WIDTH-1:0] byp_rd;
    logic [WIDTH-1:0] rd_q;

    if (USE_BRAM) begin : g_bram
      (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

      // Byte-masked commit into this copy
      always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
          if (we_be[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end

      assign mem_rd = mem[raddr[c]];
    end else begin : g_dist
      (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [DEPTH];

      // Byte-masked commit into this copy
      always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
          if (we_be[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end

      assign mem_rd = mem[raddr[c]];
    end

    // Forward the bytes being committed this cycle when addresses match
    always_comb begin
      byp_rd = mem_rd;
      if (raddr[c] == waddr) begin
        for (int b = 0; b < NB; b++) begin
          if (we_be[b]) byp_rd[b*8 +: 8] = wdata[b*8 +: 8];
        end
      end
    end

    // Registered read port; holds when not enabled, zeroed while flushing
    always_ff @(posedge clk or posedge rst) begin
      if (rst)         rd_q <= '0;
      else if (rflush) rd_q <= '0;
      else if (ren[c]) rd_q <= byp_rd;
    end

    assign rdata[c] = rd_q;
  end

endmodule

// File: rtl/vrf_xor_mp.sv
// vrf_xor_mp: multi-port vector register file slice built from XOR banks.
// One bank per write port; the logical word is the XOR of all banks.
// Writes take two stages: stage 1 reads the other banks at the write
// address, stage 2 stores din ^ (other banks) into the port's own bank.
// A clear sequencer zeroes the whole array one address per cycle.
// Build option: define VRF_CLEAR_ON_RESET_EN to run the clear sweep
// automatically after reset; otherwise the array is ready one cycle after
// reset release with undefined contents.
//
// state    | meaning
// ST_IDLE  | one cycle after reset, picks clear sweep or ready
// ST_CLEAR | zero sweep in progress, writes/reads blocked, dout forced 0
// ST_READY | normal operation
module vrf_xor_mp
  import vrf_pkg::*;
#(
  parameter int    R_PORTS_NUM  = 4,
  parameter int    W_PORTS_NUM  = 3,
  parameter int    MEM_DEPTH    = 512,
  parameter int    MEM_WIDTH    = 32,
  parameter int    NUM_OF_BYTES = MEM_WIDTH / 8,
  parameter int    READ_LAT     = 1,
  parameter string RAM_TYPE     = "DISTRAM"
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          clear_i,
  output logic                                          ready_o,
  input  logic [R_PORTS_NUM-1:0][$clog2(MEM_DEPTH)-1:0] raddr_i,
  input  logic [R_PORTS_NUM-1:0]                        ren_i,
  output logic [R_PORTS_NUM-1:0][MEM_WIDTH-1:0]         dout_o,
  input  logic [W_PORTS_NUM-1:0][$clog2(MEM_DEPTH)-1:0] waddr_i,
  input  logic [W_PORTS_NUM-1:0][NUM_OF_BYTES-1:0]      bwe_i,
  input  logic [W_PORTS_NUM-1:0]                        wen_i,
  input  logic [W_PORTS_NUM-1:0][MEM_WIDTH-1:0]         din_i
);

  localparam int AW       = addr_w(MEM_DEPTH);
  localparam int NB       = NUM_OF_BYTES;
  localparam int WP       = W_PORTS_NUM;
  localparam int RP       = R_PORTS_NUM;
  localparam int N_COPIES = RP + WP - 1;
  localparam bit USE_BRAM = (RAM_TYPE == "BRAM");

  typedef logic [AW-1:0]        addr_t;
  typedef logic [NB-1:0]        be_t;
  typedef logic [MEM_WIDTH-1:0] word_t;

  vrf_state_e state_q, state_d;
  addr_t      clr_cnt_q, clr_cnt_d;
  logic       clearing;
  logic       ready;

  assign clearing = (state_q == ST_CLEAR);
  assign ready    = (state_q == ST_READY);
  assign ready_o  = ready;

  // Clear sequencer state and sweep address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Clear sequencer next state; clear_i during a sweep restarts it at 0
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_IDLE: begin
`ifdef VRF_CLEAR_ON_RESET_EN
        state_d   = ST_CLEAR;
`else
        state_d   = ST_READY;
`endif
        clr_cnt_d = '0;
      end
      ST_CLEAR: begin
        if (clear_i) begin
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
          if (clr_cnt_q == AW'(MEM_DEPTH - 1)) state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (clear_i) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clr_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------- stage 1
  logic [WP-1:0]        acc;
  logic [WP-1:0][NB-1:0] bwe_m;

  // Acceptance and same-address collision masking: a higher port takes
  // every byte it enables, lower ports keep only the rest
  always_comb begin
    acc   = '0;
    bwe_m = bwe_i;
    for (int p = 0; p < WP; p++) begin
      acc[p] = wen_i[p] & (|bwe_i[p]) & ready;
    end
    for (int p = 0; p < WP; p++) begin
      for (int q = p + 1; q < WP; q++) begin
        if (acc[q] && (waddr_i[q] == waddr_i[p])) bwe_m[p] = bwe_m[p] & ~bwe_i[q];
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic  [WP-1:0] s2_vld;
  addr_t [WP-1:0] s2_addr;
  word_t [WP-1:0] s2_din;
  be_t   [WP-1:0] s2_be;

  // Stage-2 registers; a write accepted alongside clear_i never commits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld  <= '0;
      s2_addr <= '0;
      s2_din  <= '0;
      s2_be   <= '0;
    end else begin
      s2_vld <= acc & {WP{~clear_i}};
      for (int p = 0; p < WP; p++) begin
        if (acc[p]) begin
          s2_addr[p] <= waddr_i[p];
          s2_din[p]  <= din_i[p];
          s2_be[p]   <= bwe_m[p];
        end
      end
    end
  end

  logic [WP-1:0][N_COPIES-1:0][MEM_WIDTH-1:0] bank_rdata;
  word_t [WP-1:0][WP-1:0] lvt_val;   // [port][bank], own bank reads as 0
  word_t [RP-1:0][WP-1:0] usr_val;   // [read port][bank]
  word_t [WP-1:0]         cm_data;
  logic  [WP-1:0]         cm_en;
  be_t   [WP-1:0]         bk_be;
  addr_t [WP-1:0]         bk_addr;
  word_t [WP-1:0]         bk_data;

  for (genvar p = 0; p < WP; p++) begin : g_lvt_map
    for (genvar q = 0; q < WP; q++) begin : g_src
      if (q != p) begin : g_other
        assign lvt_val[p][q] = bank_rdata[q][lvt_copy_idx(p, q)];
      end else begin : g_self
        assign lvt_val[p][q] = '0;
      end
    end
  end

  for (genvar r = 0; r < RP; r++) begin : g_usr_map
    for (genvar q = 0; q < WP; q++) begin : g_src
      assign usr_val[r][q] = bank_rdata[q][WP - 1 + r];
    end
  end

  // Commit value: new data folded with the other banks so the XOR of all
  // banks equals din in the enabled bytes
  always_comb begin
    cm_data = '0;
    cm_en   = '0;
    for (int p = 0; p < WP; p++) begin
      cm_en[p]   = s2_vld[p] & ~clear_i & ready;
      cm_data[p] = s2_din[p];
      for (int q = 0; q < WP; q++) begin
        cm_data[p] = cm_data[p] ^ lvt_val[p][q];
      end
    end
  end

  // Bank write port: the clear sweep overrides any pending commit
  always_comb begin
    bk_be   = '0;
    bk_addr = '0;
    bk_data = '0;
    for (int p = 0; p < WP; p++) begin
      if (clearing) begin
        bk_be[p]   = '1;
        bk_addr[p] = clr_cnt_q;
        bk_data[p] = '0;
      end else begin
        bk_be[p]   = cm_en[p] ? s2_be[p] : '0;
        bk_addr[p] = s2_addr[p];
        bk_data[p] = cm_data[p];
      end
    end
  end

  for (genvar b = 0; b < WP; b++) begin : g_bank
    logic [N_COPIES-1:0][AW-1:0] b_raddr;
    logic [N_COPIES-1:0]         b_ren;

    for (genvar c = 0; c < WP - 1; c++) begin : g_lvt
      assign b_raddr[c] = waddr_i[lvt_port_of(b, c)];
      assign b_ren[c]   = acc[lvt_port_of(b, c)];
    end

    for (genvar r = 0; r < RP; r++) begin : g_usr
      assign b_raddr[WP - 1 + r] = raddr_i[r];
      assign b_ren[WP - 1 + r]   = ren_i[r] & ~clearing;
    end

    vrf_xor_bank #(
      .DEPTH    (MEM_DEPTH),
      .WIDTH    (MEM_WIDTH),
      .NB       (NB),
      .N_COPIES (N_COPIES),
      .USE_BRAM (USE_BRAM)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .we_be  (bk_be[b]),
      .waddr  (bk_addr[b]),
      .wdata  (bk_data[b]),
      .raddr  (b_raddr),
      .ren    (b_ren),
      .rflush (clearing),
      .rdata  (bank_rdata[b])
    );
  end

  // ---------------------------------------------------------------- read out
  word_t [RP-1:0] rd_xor;
  word_t [RP-1:0] dout_pre;

  // Logical read word: XOR of every bank's user copy
  always_comb begin
    rd_xor = '0;
    for (int r = 0; r < RP; r++) begin
      for (int q = 0; q < WP; q++) begin
        rd_xor[r] = rd_xor[r] ^ usr_val[r][q];
      end
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic  [RP-1:0] ren_q;
    word_t [RP-1:0] dout_q;

    // Extra output register stage, loads one cycle after an enabled read
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ren_q  <= '0;
        dout_q <= '0;
      end else begin
        ren_q <= ren_i & {RP{~clearing}};
        for (int r = 0; r < RP; r++) begin
          if (clearing)      dout_q[r] <= '0;
          else if (ren_q[r]) dout_q[r] <= rd_xor[r];
        end
      end
    end

    assign dout_pre = dout_q;
  end else begin : g_lat1
    assign dout_pre = rd_xor;
  end

  assign dout_o = clearing ? '0 : dout_pre;

endmodule

// File: tb/tb_vrf_xor_mp.sv
// tb_vrf_xor_mp: directed vectors with hand-computed expectations for
// vrf_xor_mp at default parameters (4R/3W, 512x32, READ_LAT=1).
module tb_vrf_xor_mp;

  logic              clk;
  logic              rst;
  logic              clear_i;
  logic              ready_o;
  logic [3:0][8:0]   raddr_i;
  logic [3:0]        ren_i;
  logic [3:0][31:0]  dout_o;
  logic [2:0][8:0]   waddr_i;
  logic [2:0][3:0]   bwe_i;
  logic [2:0]        wen_i;
  logic [2:0][31:0]  din_i;

  int total;
  int bad;
  int n;

  vrf_xor_mp dut (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear_i),
    .ready_o (ready_o),
    .raddr_i (raddr_i),
    .ren_i   (ren_i),
    .dout_o  (dout_o),
    .waddr_i (waddr_i),
    .bwe_i   (bwe_i),
    .wen_i   (wen_i),
    .din_i   (din_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen_i   = '0;
    ren_i   = '0;
    bwe_i   = '0;
    clear_i = 1'b0;
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d, input logic [3:0] be);
    wen_i[p]   = 1'b1;
    waddr_i[p] = a[8:0];
    din_i[p]   = d;
    bwe_i[p]   = be;
  endtask

  task automatic rd(input int r, input int a);
    ren_i[r]   = 1'b1;
    raddr_i[r] = a[8:0];
  endtask

  // counts post-edge samples with ready low, bounded
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!ready_o && cnt < 2000) begin
      cnt++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle();
    raddr_i = '0;
    waddr_i = '0;
    din_i   = '0;
    repeat (3) step();
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_dout0", dout_o[0], 32'd0);
    chk("rst_dout3", dout_o[3], 32'd0);
    rst = 1'b0;

`ifdef VRF_CLEAR_ON_RESET_EN
    // one IDLE cycle, then 512 clear cycles
    step();
    wait_ready(n);
    chk("por_len", 32'(n), 32'd512);
`else
    chk("rdy_pre", 32'(ready_o), 32'd0);
    step();
    chk("rdy_norst", 32'(ready_o), 32'd1);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    wait_ready(n);
    chk("clr_len", 32'(n), 32'd512);
`endif

    // whole array reads zero on every port
    for (int i = 0; i < 128; i++) begin
      for (int r = 0; r < 4; r++) rd(r, 4 * i + r);
      step();
      for (int r = 0; r < 4; r++) chk("zero", dout_o[r], 32'd0);
    end
    idle();

    // two ports write in one cycle, read next cycle
    wr(0, 5, 32'hDEADBEEF, 4'hF);
    wr(1, 6, 32'h12345678, 4'hF);
    step();
    idle();
    rd(0, 5);
    rd(1, 6);
    step();
    idle();
    chk("wr2_p0", dout_o[0], 32'hDEADBEEF);
    chk("wr2_p1", dout_o[1], 32'h12345678);

    // ren low keeps the last read word
    raddr_i[0] = 9'd6;
    step();
    chk("hold", dout_o[0], 32'hDEADBEEF);

    // back-to-back full then partial write to one address
    wr(0, 10, 32'h11111111, 4'hF);
    step();
    idle();
    wr(2, 10, 32'h0000ABCD, 4'h3);
    step();
    idle();
    rd(2, 10);
    step();
    idle();
    chk("b2b", dout_o[2], 32'h1111ABCD);

    // same-cycle collisions
    wr(0, 3, 32'hAAAAAAAA, 4'hF);
    wr(2, 3, 32'h55555555, 4'h3);
    step();
    idle();
    wr(1, 8, 32'h12345678, 4'hF);
    wr(2, 8, 32'hFFFFFFFF, 4'h9);
    rd(3, 3);
    step();
    idle();
    chk("coll3", dout_o[3], 32'hAAAA5555);
    rd(3, 8);
    step();
    idle();
    chk("coll8", dout_o[3], 32'hFF3456FF);

    // enable with no bytes is not a write
    wr(0, 12, 32'hFFFFFFFF, 4'h0);
    step();
    idle();
    rd(1, 12);
    step();
    idle();
    chk("nobe", dout_o[1], 32'd0);

    // address boundaries
    wr(2, 511, 32'hA5A55A5A, 4'hF);
    wr(0, 0, 32'h00000001, 4'hF);
    step();
    idle();
    rd(0, 511);
    rd(1, 0);
    step();
    idle();
    chk("addr511", dout_o[0], 32'hA5A55A5A);
    chk("addr0", dout_o[1], 32'h00000001);

    // read in the write cycle sees old data, next cycle sees new
    wr(1, 7, 32'h0BADF00D, 4'hF);
    step();
    idle();
    step();
    wr(1, 7, 32'hCAFE0000, 4'hF);
    rd(3, 7);
    step();
    idle();
    chk("old7", dout_o[3], 32'h0BADF00D);
    rd(3, 7);
    step();
    idle();
    chk("new7", dout_o[3], 32'hCAFE0000);

    // clear while a write sits in stage 2; writes and reads blocked during sweep
    wr(0, 7, 32'h77777777, 4'hF);
    step();
    idle();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    rd(0, 7);
    n = 0;
    while (!ready_o && n < 2000) begin
      n++;
      if (n == 100) chk("clr_dout", dout_o[0], 32'd0);
      if (n == 50) wr(1, 20, 32'h20202020, 4'hF);
      else wen_i = '0;
      step();
    end
    idle();
    chk("drop_len", 32'(n), 32'd512);
    rd(0, 7);
    rd(1, 20);
    step();
    idle();
    chk("drop7", dout_o[0], 32'd0);
    chk("blk20", dout_o[1], 32'd0);

    // clear_i during a sweep restarts the counter
    wr(2, 5, 32'h5A5A5A5A, 4'hF);
    step();
    idle();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    repeat (100) step();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    wait_ready(n);
    chk("restart_len", 32'(n), 32'd512);
    rd(2, 5);
    step();
    idle();
    chk("clr5", dout_o[2], 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
